store_buffer: RTL and testbench

- Small word-granular write buffer between the MEM-stage pipeline control (MemRead/MemWrite/Address/WriteData) and the data memory.
- Absorbs stores in a FIFO and drains them to memory on cycles when the pipeline is not using the memory port.
- Services loads by forwarding from the buffer, youngest matching entry first; on a miss, the load passes through to memory.
- Asserts Stall only when a store arrives and the FIFO is full.

---
 rtl/store_buf_pkg.sv | 14 +
 rtl/store_buf_fwd_match.sv | 28 ++
 rtl/store_buffer.sv | 98 +++++++++
 tb/tb_store_buffer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/store_buf_pkg.sv
// store_buf_pkg: shared widths, entry layout and pointer sizing for the store buffer.
package store_buf_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  typedef struct packed {
    logic valid;
    logic [SB_ADDR_W-3:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/store_buf_fwd_match.sv
// store_buf_fwd_match: youngest-first word-index match over the buffer entries.
module store_buf_fwd_match import store_buf_pkg::*; #(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_ADDR_W - 2
) (
  input  logic [DEPTH-1:0]               valid_i,
  input  logic [DEPTH-1:0][AW-1:0]       addr_i,
  input  logic [ptr_w(DEPTH)-1:0]        tail_i,
  input  logic [AW-1:0]                  word_i,
  output logic                           hit_o,
  output logic [ptr_w(DEPTH)-1:0]        idx_o
);
  localparam int PW = ptr_w(DEPTH);
  logic [PW-1:0] j;
  // walk oldest to youngest so the last match (nearest tail-1) wins
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    j = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      j = tail_i - PW'(k);
      if (valid_i[j] && addr_i[j] == word_i) begin
        hit_o = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: word-granular store FIFO with load forwarding and idle-cycle drain.
// Optional in-place store merging when STORE_BUF_MERGE_EN is defined.
module store_buffer import store_buf_pkg::*; #(
  parameter int DEPTH = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              Empty,
  output logic [ADDR_W-1:0] DmAddress,
  output logic [DATA_W-1:0] DmWriteData,
  output logic              DmMemRead,
  output logic              DmMemWrite,
  input  logic [DATA_W-1:0] DmReadData
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = ADDR_W - 2;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef struct packed {
    logic valid;
    logic [AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;
  ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [PW:0] count_q, count_d;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0][AW-1:0] addrs;
  logic [AW-1:0] word;
  logic hit, load, store, merge, enq, drain;
  assign word = Address[ADDR_W-1:2];
  always_comb begin
    vld = '0;
    addrs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = ent_q[i].valid;
      addrs[i] = ent_q[i].addr;
    end
  end
  store_buf_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
    .valid_i(vld),
    .addr_i (addrs),
    .tail_i (tail_q),
    .word_i (word),
    .hit_o  (hit),
    .idx_o  (idx)
  );
  // a simultaneous read and write is resolved as a load
  assign load = MemRead;
  assign store = MemWrite & ~MemRead;
`ifdef STORE_BUF_MERGE_EN
  assign merge = store & hit;
`else
  assign merge = 1'b0;
`endif
  assign Stall = store & ~merge & (count_q == FULL);
  assign enq = store & ~merge & ~Stall;
  assign drain = ~load & (~store | Stall) & (count_q != '0);
  assign Empty = count_q == '0;
  assign DmMemWrite = drain;
  assign DmMemRead = load & ~hit;
  assign DmAddress = drain ? {ent_q[head_q].addr, 2'b00} : DmMemRead ? Address : '0;
  assign DmWriteData = drain ? ent_q[head_q].data : '0;
  assign ReadData = !load ? '0 : hit ? ent_q[idx].data : DmReadData;
  always_comb begin
    ent_d = ent_q;
    head_d = head_q + PW'(drain);
    tail_d = tail_q + PW'(enq);
    count_d = count_q + (PW+1)'(enq) - (PW+1)'(drain);
    if (enq) ent_d[tail_q] = '{valid: 1'b1, addr: word, data: WriteData};
    if (merge) ent_d[idx].data = WriteData;
    if (drain) ent_d[head_q].valid = 1'b0;
  end
  // entry payloads are left unreset; only occupancy state is cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      ent_q <= ent_d;
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) if (!reset) assert (!(MemRead && MemWrite));
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer with a behavioural memory.
module tb_store_buffer;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset, MemRead, MemWrite, Stall, Empty, DmMemRead, DmMemWrite;
  logic [31:0] Address, WriteData, ReadData, DmAddress, DmWriteData, DmReadData;
  logic [31:0] mem [0:63];
  logic [31:0] mm [0:63];
  typedef struct {logic [29:0] w; logic [31:0] d;} ent_t;
  ent_t sb_q[$];
  ent_t exp_dq[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .Empty(Empty), .DmAddress(DmAddress), .DmWriteData(DmWriteData),
    .DmMemRead(DmMemRead), .DmMemWrite(DmMemWrite), .DmReadData(DmReadData)
  );
  always_comb DmReadData = mem[DmAddress[7:2]];
  always @(posedge clk) if (DmMemWrite && !reset) mem[DmAddress[7:2]] <= DmWriteData;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] d);
    logic stall, wr, emp;
    logic [31:0] rd;
    int hi;
    ent_t e;
    stall = 1'b0;
    wr = 1'b0;
    rd = '0;
    hi = -1;
    emp = sb_q.size() == 0;
    MemRead = mr;
    MemWrite = mw;
    Address = a;
    WriteData = d;
    for (int i = sb_q.size() - 1; i >= 0 && hi < 0; i--) if (sb_q[i].w == a[31:2]) hi = i;
    if (mr) rd = hi >= 0 ? sb_q[hi].d : mm[a[7:2]];
    else if (mw) begin
`ifdef STORE_BUF_MERGE_EN
      if (hi >= 0) sb_q[hi].d = d; else
`endif
      if (sb_q.size() < DEPTH) sb_q.push_back('{a[31:2], d});
      else begin
        stall = 1'b1;
        wr = 1'b1;
      end
    end else wr = sb_q.size() > 0;
    if (wr) begin
      e = sb_q.pop_front();
      exp_dq.push_back(e);
      mm[e.w[5:0]] = e.d;
    end
    @(negedge clk);
    chk("empty", {31'b0, Empty}, {31'b0, emp});
    chk("stall", {31'b0, Stall}, {31'b0, stall});
    chk("dm_wr", {31'b0, DmMemWrite}, {31'b0, wr});
    chk("dm_rd", {31'b0, DmMemRead}, {31'b0, mr && hi < 0});
    chk("rdata", ReadData, rd);
    if (mr && hi < 0) chk("dm_addr_load", DmAddress, a);
    if (!mr && !wr) chk("dm_addr_idle", DmAddress, 32'h0);
    if (DmMemWrite) begin
      if (exp_dq.size() == 0) chk("drain_extra", {31'b0, DmMemWrite}, 32'h0);
      else begin
        e = exp_dq.pop_front();
        chk("drain_addr", DmAddress, {e.w, 2'b00});
        chk("drain_data", DmWriteData, e.d);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    exp_dq.delete();
  endtask
  initial begin
    int op;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      mem[i] = i == 5 ? 32'hDEADBEEF : 32'hC0DE0000 + i;
      mm[i] = mem[i];
    end
    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    Address = '0;
    WriteData = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) cyc(0, 0, 0, 0);
    cyc(1, 0, 20, 0);
    cyc(0, 1, 20, 32'h11111111);
    cyc(1, 0, 20, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, i * 4, 32'h100 + i);
    cyc(0, 1, 16, 32'h104);
    cyc(0, 1, 16, 32'h104);
    repeat (6) cyc(0, 0, 0, 0);
    cyc(0, 1, 8, 32'hA);
    cyc(0, 1, 8, 32'hB);
    cyc(1, 0, 8, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 20, 32'h22223333);
    cyc(1, 0, 22, 0);
    repeat (2) cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, i * 4, 32'h300 + i);
    do_reset();
    repeat (4) cyc(0, 0, 0, 0);
    repeat (300) begin
      op = $urandom_range(0, 2);
      a = $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
      cyc(op == 1, op == 2, a, $urandom);
    end
    repeat (6) cyc(0, 0, 0, 0);
    cyc(1, 0, 4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
